// File: rtl/gemm_result_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_drain_pkg
//  Description : Shared types and constants for the GeMM result drain.
//  Revision    : 1.0 - initial release
// ============================================================================
package gemm_drain_pkg;

  // Drain controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Output skid buffer depth; two entries cover one registered read in
  // flight plus one beat held under backpressure.
  localparam int unsigned DrainFifoDepth = 2;

endpackage
`default_nettype wire

// File: rtl/gemm_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_drain_if
//  Description : Control, C-SRAM read port and output stream of the result
//                drain. The master modport is the drain side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gemm_drain_if #(
  parameter int ADDR_WIDTH      = 12,
  parameter int OUT_DATA_WIDTH  = 32,
  parameter int SIZE_ADDR_WIDTH = 8
);
  logic                              start_i;
  logic [SIZE_ADDR_WIDTH-1:0]        M_rows_i;
  logic [SIZE_ADDR_WIDTH-1:0]        N_cols_i;
  logic                              busy_o;
  logic                              done_o;
  logic [ADDR_WIDTH-1:0]             C_addr_o;
  logic signed [OUT_DATA_WIDTH-1:0]  C_rd_data_i;
  logic                              out_valid_o;
  logic                              out_ready_i;
  logic signed [OUT_DATA_WIDTH-1:0]  out_data_o;
  logic                              out_last_o;

  modport master (
    input  start_i, M_rows_i, N_cols_i, C_rd_data_i, out_ready_i,
    output busy_o, done_o, C_addr_o, out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    output start_i, M_rows_i, N_cols_i, C_rd_data_i, out_ready_i,
    input  busy_o, done_o, C_addr_o, out_valid_o, out_data_o, out_last_o
  );
endinterface
`default_nettype wire

// File: rtl/gemm_result_drain_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : drain_skid_fifo
//  Description : Small register FIFO over {last, data}. Head is presented
//                combinationally from storage, so it is stable while stalled.
//                Depth must be a power of two so the pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module drain_skid_fifo
  import gemm_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                          clk_i,
  input  wire logic                          rst_ni,
  input  wire logic                          push_i,
  input  wire logic signed [DATA_WIDTH-1:0]  push_data_i,
  input  wire logic                          push_last_i,
  input  wire logic                          pop_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(DrainFifoDepth+1)-1:0] count_o,
  output logic signed [DATA_WIDTH-1:0]       head_data_o,
  output logic                               head_last_o
);
  localparam int CNT_W = $clog2(DrainFifoDepth + 1);
  localparam int PTR_W = $clog2(DrainFifoDepth);

  logic signed [DATA_WIDTH-1:0] r_data [DrainFifoDepth];
  logic                         r_last [DrainFifoDepth];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic                         w_pop;

  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == CNT_W'(DrainFifoDepth));
  assign count_o     = r_count;
  assign head_data_o = r_data[r_rd_ptr];
  assign head_last_o = r_last[r_rd_ptr];
  assign w_pop       = pop_i & ~empty_o;

  // Storage, pointers and occupancy; push and pop together keep the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DrainFifoDepth; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_data[r_wr_ptr] <= push_data_i;
        r_last[r_wr_ptr] <= push_last_i;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({push_i, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/gemm_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_result_drain
//  Description : Streams the row-major C matrix out of the single-port output
//                SRAM. Hides the one-cycle read latency and absorbs
//                backpressure with a two-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module gemm_result_drain
  import gemm_drain_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int OUT_DATA_WIDTH  = 32,
  parameter int SIZE_ADDR_WIDTH = 8
) (
  input  wire logic   clk_i,
  input  wire logic   rst_ni,
  gemm_drain_if.master bus
);
  // Element count is the full product width so 2^ADDR_WIDTH is representable
  localparam int CNT_W  = 2 * SIZE_ADDR_WIDTH;
  localparam int FCNT_W = $clog2(DrainFifoDepth + 1);

  drain_state_e       r_state;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_push_idx;
  logic               r_inflight;
  logic               r_busy;
  logic               r_done;

  logic [CNT_W-1:0]   w_product;
  logic [FCNT_W-1:0]  w_fifo_cnt;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_unused_full;
  logic               w_fifo_last;
  logic               w_pop;
  logic               w_push_last;
  logic [FCNT_W:0]    w_occupancy;
  logic               w_issue;

  assign w_product = CNT_W'(bus.M_rows_i) * CNT_W'(bus.N_cols_i);

  assign w_pop       = ~w_fifo_empty & bus.out_ready_i;
  assign w_push_last = (r_push_idx == r_total - CNT_W'(1));

  // Buffered beats plus the read in flight, minus what leaves this cycle,
  // must stay below the buffer depth for another read to be issued.
  assign w_occupancy = (FCNT_W + 1)'(w_fifo_cnt) + (FCNT_W + 1)'(r_inflight);
  assign w_issue     = (r_state == DRAIN) && (r_rd_cnt < r_total) &&
                       (w_occupancy < (FCNT_W + 1)'(DrainFifoDepth) + (FCNT_W + 1)'(w_pop));

  // Full flag is implied by the issue rule and not needed here
  assign w_unused_full = w_fifo_full;

  assign bus.C_addr_o    = r_rd_cnt[ADDR_WIDTH-1:0];
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.out_valid_o = ~w_fifo_empty;
  assign bus.out_last_o  = w_fifo_last;

  // Drain FSM, read/push counters and the in-flight flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_total    <= '0;
      r_rd_cnt   <= '0;
      r_push_idx <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
      if (r_inflight) begin
        r_push_idx <= r_push_idx + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_total    <= w_product;
            r_rd_cnt   <= '0;
            r_push_idx <= '0;
            if (w_product == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
              r_busy  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_fifo_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  drain_skid_fifo #(
    .DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_inflight),
    .push_data_i (bus.C_rd_data_i),
    .push_last_i (w_push_last),
    .pop_i       (w_pop),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_cnt),
    .head_data_o (bus.out_data_o),
    .head_last_o (w_fifo_last)
  );
endmodule
`default_nettype wire

// File: tb/tb_gemm_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gemm_result_drain
//  Description : Self-checking bench for gemm_result_drain. The C SRAM holds
//                mem[i] = 3*i - 7; every beat is checked against that rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_result_drain;

  typedef struct {
    int m;
    int n;
    int mode;          // 0: ready=1, 1: stall 5 cycles at beat 10 then random, 2: random
    int restart_at;    // cycle index at which start is re-pulsed, -1 for none
    int reset_at;      // accepted-beat count at which reset is applied, -1 for none
    int exp_beats;
    int exp_dones;
    int exp_done_idx;  // cycle index of done relative to start, -1 = not fixed
  } vec_t;

  localparam int NV = 9;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NV];
  logic signed [31:0] mem [4096];

  gemm_drain_if #(.ADDR_WIDTH(12), .OUT_DATA_WIDTH(32), .SIZE_ADDR_WIDTH(8)) bus ();

  gemm_result_drain #(
    .ADDR_WIDTH      (12),
    .OUT_DATA_WIDTH  (32),
    .SIZE_ADDR_WIDTH (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM read: data valid one cycle after the address
  always @(posedge clk) bus.C_rd_data_i <= mem[bus.C_addr_o];

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_busy"},  bus.busy_o, 0);
    check({nm, "_done"},  bus.done_o, 0);
    check({nm, "_valid"}, bus.out_valid_o, 0);
    check({nm, "_last"},  bus.out_last_o, 0);
    check({nm, "_addr"},  bus.C_addr_o, 0);
    check({nm, "_data"},  bus.out_data_o, 0);
  endtask

  task automatic run_drain(input vec_t v);
    int total, beats, dones, done_idx, last_acc, stall_left, budget;
    bit stall_started, prev_stall, saw_valid, addr_moved, rdy;
    logic signed [31:0] prev_data;
    logic prev_last;
    logic [11:0] addr0;
    total = v.m * v.n;
    beats = 0; dones = 0; done_idx = -1; last_acc = -1; stall_left = 0;
    stall_started = 0; prev_stall = 0; saw_valid = 0; addr_moved = 0;
    prev_data = '0; prev_last = 1'b0;
    budget = total * 8 + 40;

    @(negedge clk);
    bus.M_rows_i = 8'(v.m);
    bus.N_cols_i = 8'(v.n);
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    addr0 = bus.C_addr_o;

    for (int idx = 0; idx < budget; idx++) begin
      if (idx == 0) begin
        check("start_busy", bus.busy_o, (total != 0));
        if (total != 0) check("start_addr", bus.C_addr_o, 0);
      end
      if (v.reset_at >= 0 && beats == v.reset_at) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) begin
          @(negedge clk);
          check("midreset_no_done", bus.done_o, 0);
          check("midreset_no_valid", bus.out_valid_o, 0);
        end
        rst_n = 1'b1;
        break;
      end

      bus.start_i = (idx == v.restart_at);
      if (idx == v.restart_at) begin
        bus.M_rows_i = 8'd2;
        bus.N_cols_i = 8'd2;
      end

      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (v.mode == 1 && !stall_started && beats == 10) begin
        stall_started = 1'b1;
        stall_left    = 4;
        rdy           = 1'b0;
      end else if (v.mode == 2 || (v.mode == 1 && stall_started)) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      bus.out_ready_i = rdy;

      if (bus.C_addr_o != addr0) addr_moved = 1'b1;
      if (bus.out_valid_o) saw_valid = 1'b1;
      if (bus.done_o) begin
        dones++;
        if (done_idx < 0) done_idx = idx;
      end
      if (prev_stall) begin
        check("stall_valid_held", bus.out_valid_o, 1);
        check("stall_data_held", bus.out_data_o, prev_data);
        check("stall_last_held", bus.out_last_o, prev_last);
      end
      if (bus.busy_o) begin
        check("buffer_bound", (int'(bus.C_addr_o) - beats) <= 2, 1);
      end
      if (bus.out_valid_o && rdy) begin
        check("beat_data", bus.out_data_o, beats * 3 - 7);
        check("beat_last", bus.out_last_o, (beats == total - 1));
        last_acc = idx;
        beats++;
      end
      prev_stall = bus.out_valid_o && !rdy;
      prev_data  = bus.out_data_o;
      prev_last  = bus.out_last_o;

      if (done_idx >= 0 && idx >= done_idx + 2) break;
      @(negedge clk);
    end

    bus.start_i     = 1'b0;
    bus.out_ready_i = 1'b1;

    check("beat_count", beats, v.exp_beats);
    check("done_count", dones, v.exp_dones);
    if (v.exp_done_idx >= 0) check("done_cycle", done_idx, v.exp_done_idx);
    if (v.exp_dones > 0 && total > 0) check("done_after_last", done_idx, last_acc + 1);
    if (total == 0) begin
      check("zero_no_valid", saw_valid, 0);
      check("zero_no_sweep", addr_moved, 0);
    end
  endtask

  initial begin
    int rm, rn;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4096; i++) mem[i] = i * 3 - 7;

    rm = $urandom_range(1, 7);
    rn = $urandom_range(1, 7);
    vecs[0] = '{4,  4,  0, -1, -1, 16,   1, 18};
    vecs[1] = '{8,  8,  1, -1, -1, 64,   1, -1};
    vecs[2] = '{0,  5,  0, -1, -1, 0,    1, 0};
    vecs[3] = '{4,  4,  0,  5, -1, 16,   1, 18};
    vecs[4] = '{4,  8,  0, -1,  6, 6,    0, -1};
    vecs[5] = '{2,  2,  0, -1, -1, 4,    1, 6};
    vecs[6] = '{32, 32, 0, -1, -1, 1024, 1, 1026};
    vecs[7] = '{rm, rn, 2, -1, -1, rm * rn, 1, -1};
    vecs[8] = '{5,  0,  0, -1, -1, 0,    1, 0};

    rst_n           = 1'b1;
    bus.start_i     = 1'b0;
    bus.M_rows_i    = '0;
    bus.N_cols_i    = '0;
    bus.out_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_drain(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
